// File: rtl/regfile_pkg.sv
// Shared types for the register file with pending-bit scoreboard.
// Default widths, FSM encoding and the read-port request bundle.
package regfile_pkg;

  localparam int RF_DATA_W   = 16;
  localparam int RF_ADDR_W   = 4;
  // Request addresses are carried at this width; ports slice what they use.
  localparam int RF_ADDR_MAX = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

  typedef struct packed {
    logic                   en;
    logic [RF_ADDR_MAX-1:0] addr;
  } rd_req_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: decode, write-first bypass, zero-reg
// masking and the busy flag taken from next-state pending bits.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  rd_req_t              i_req,
  input  logic                 i_wr_en,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [DATA_W-1:0]    i_wr_data,
  input  logic [DATA_W-1:0]    i_mem [2**ADDR_W],
  input  logic [2**ADDR_W-1:0] i_pend_nxt,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_busy
);

  logic [ADDR_W-1:0]      w_addr;
  logic [RF_ADDR_MAX-1:0] w_unused_addr;
  logic                   w_zero;
  logic                   w_hit;
  logic [DATA_W-1:0]      w_data;
  logic                   w_busy;

  assign w_addr        = i_req.addr[ADDR_W-1:0];
  assign w_unused_addr = i_req.addr >> ADDR_W;
  assign w_zero        = (ZERO_REG != 0) && (w_addr == '0);
  assign w_hit         = i_wr_en && (i_wr_addr == w_addr);

  // Select zero, bypassed write data or stored data; busy from next pending.
  always_comb begin
    w_data = i_mem[w_addr];
    w_busy = i_pend_nxt[w_addr];
    if (w_hit) w_data = i_wr_data;
    if (w_zero) begin
      w_data = '0;
      w_busy = 1'b0;
    end
  end

  // Capture on request, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_data <= '0;
      o_busy <= 1'b0;
    end else if (i_req.en) begin
      o_data <= w_data;
      o_busy <= w_busy;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with pending bits, bypass and a post-reset init sweep
// that writes one register per cycle before requests are accepted.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int INIT_INDEX = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              init_busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [DEPTH-1:0]  w_pend_nxt;

  logic              w_run;
  logic              w_wr_ok;
  logic              w_rsv_ok;
  logic [ADDR_W-1:0] w_init_idx;
  logic [DATA_W-1:0] w_init_val;
  rd_req_t           w_req_a;
  rd_req_t           w_req_b;

  assign w_run      = (r_state == ST_RUN);
  assign init_busy  = (r_state == ST_INIT);
  assign w_init_idx = r_cnt[ADDR_W-1:0];
  assign w_init_val = (INIT_INDEX != 0) ? DATA_W'(w_init_idx) : '0;
  assign w_wr_ok    = w_run && wr_en &&
                      !((ZERO_REG != 0) && (wr_addr == '0));
  assign w_rsv_ok   = w_run && rsv_en &&
                      !((ZERO_REG != 0) && (rsv_addr == '0));

  // FSM state and init counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Init sweep advances one register per cycle, then hands over to RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_INIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_cnt_nxt == CNT_W'(DEPTH)) w_state_nxt = ST_RUN;
      end
      ST_RUN: ;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Next pending vector: write clears, a same-cycle reservation wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_ok)  w_pend_nxt[wr_addr]  = 1'b0;
    if (w_rsv_ok) w_pend_nxt[rsv_addr] = 1'b1;
  end

  // Pending bits register.
  always_ff @(posedge clk) begin
    if (reset) r_pend <= '0;
    else       r_pend <= w_pend_nxt;
  end

  // Storage: init sweep first, then the writeback port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!w_run)       r_mem[w_init_idx] <= w_init_val;
      else if (w_wr_ok) r_mem[wr_addr]    <= wr_data;
    end
  end

  // Read requests are suppressed outside RUN.
  always_comb begin
    w_req_a      = '0;
    w_req_b      = '0;
    w_req_a.en   = w_run && rd_en;
    w_req_a.addr = RF_ADDR_MAX'(rd_addr_a);
    w_req_b.en   = w_run && rd_en;
    w_req_b.addr = RF_ADDR_MAX'(rd_addr_b);
  end

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_port_a (
    .clk       (clk),
    .reset     (reset),
    .i_req     (w_req_a),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_mem     (r_mem),
    .i_pend_nxt(w_pend_nxt),
    .o_data    (rd_data_a),
    .o_busy    (busy_a)
  );

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_port_b (
    .clk       (clk),
    .reset     (reset),
    .i_req     (w_req_b),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_mem     (r_mem),
    .i_pend_nxt(w_pend_nxt),
    .o_data    (rd_data_b),
    .o_busy    (busy_b)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a default instance and a ZERO_REG
// instance share stimulus; a reference model feeds a result queue.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rsv_en;
  logic [3:0]  rsv_addr;

  logic [15:0] rd_data_a, rd_data_b;
  logic        busy_a, busy_b, init_busy;
  logic [15:0] z_data_a, z_data_b;
  logic        z_busy_a, z_busy_b, z_init_busy;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] da, db, zda, zdb;
    logic        ba, bb, zba, zbb;
  } exp_t;

  exp_t        q[$];
  exp_t        last;
  logic [15:0] m_mem [16];
  logic [15:0] m_pend;

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .DATA_W(16), .ADDR_W(4), .INIT_INDEX(1), .ZERO_REG(0)
  ) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .busy_a(busy_a), .busy_b(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .init_busy(init_busy)
  );

  regfile_scoreboard #(
    .DATA_W(16), .ADDR_W(4), .INIT_INDEX(1), .ZERO_REG(1)
  ) dut_z (
    .clk(clk), .reset(reset), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(z_data_a), .rd_data_b(z_data_b),
    .busy_a(z_busy_a), .busy_b(z_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .init_busy(z_init_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_en = 0; rd_addr_a = 0; rd_addr_b = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    rsv_en = 0; rsv_addr = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 16'(i);
    m_pend = '0;
    last = '{default: '0};
    q.delete();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic count_init(input string tag);
    int n = 0;
    chk({tag, "_busy0"}, 32'(init_busy), 32'd1);
    chk({tag, "_z_busy0"}, 32'(z_init_busy), 32'd1);
    while (init_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_len"}, 32'(n), 32'd16);
  endtask

  // One RUN cycle: drive, predict, push; then pop and compare.
  task automatic cyc(input bit rd, input logic [3:0] a, input logic [3:0] b,
                     input bit wr, input logic [3:0] wa,
                     input logic [15:0] wd,
                     input bit rv, input logic [3:0] ra);
    exp_t        e;
    exp_t        g;
    logic [15:0] p;
    logic [15:0] pz;
    rd_en = rd; rd_addr_a = a; rd_addr_b = b;
    wr_en = wr; wr_addr = wa; wr_data = wd;
    rsv_en = rv; rsv_addr = ra;
    p = m_pend;
    if (wr) p[wa] = 1'b0;
    if (rv) p[ra] = 1'b1;
    pz = p;
    pz[0] = 1'b0;
    e = last;
    if (rd) begin
      e.da  = (wr && wa == a) ? wd : m_mem[a];
      e.db  = (wr && wa == b) ? wd : m_mem[b];
      e.ba  = p[a];
      e.bb  = p[b];
      e.zda = (a == 0) ? 16'h0 : e.da;
      e.zdb = (b == 0) ? 16'h0 : e.db;
      e.zba = pz[a];
      e.zbb = pz[b];
    end
    q.push_back(e);
    last = e;
    if (wr) m_mem[wa] = wd;
    m_pend = p;
    @(posedge clk); #1;
    idle_inputs();
    if (q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
    end else begin
      g = q.pop_front();
      chk("data_a", 32'(rd_data_a), 32'(g.da));
      chk("data_b", 32'(rd_data_b), 32'(g.db));
      chk("busy_a", 32'(busy_a), 32'(g.ba));
      chk("busy_b", 32'(busy_b), 32'(g.bb));
      chk("z_data_a", 32'(z_data_a), 32'(g.zda));
      chk("z_data_b", 32'(z_data_b), 32'(g.zdb));
      chk("z_busy_a", 32'(z_busy_a), 32'(g.zba));
      chk("z_busy_b", 32'(z_busy_b), 32'(g.zbb));
    end
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    @(posedge clk); #1;

    // Reset and full init sweep.
    do_reset();
    chk("rst_data_a", 32'(rd_data_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    count_init("init");

    // Indexed init contents.
    cyc(1, 4'd5, 4'd15, 0, 0, 0, 0, 0);
    // Write then read, neighbour untouched.
    cyc(0, 0, 0, 1, 4'd3, 16'hBEEF, 0, 0);
    cyc(1, 4'd3, 4'd4, 0, 0, 0, 0, 0);
    // Write-first bypass on both ports.
    cyc(1, 4'd7, 4'd7, 1, 4'd7, 16'h1234, 0, 0);
    // Reservation, hold with rd_en low, write clears with bypass.
    cyc(0, 0, 0, 0, 0, 0, 1, 4'd9);
    cyc(1, 4'd9, 4'd3, 0, 0, 0, 0, 0);
    cyc(0, 4'd1, 4'd2, 0, 0, 0, 0, 0);
    cyc(1, 4'd9, 4'd9, 1, 4'd9, 16'h00AA, 0, 0);
    // Same-cycle reserve and write: reservation wins.
    cyc(0, 0, 0, 1, 4'd9, 16'h0055, 1, 4'd9);
    cyc(1, 4'd9, 4'd7, 0, 0, 0, 0, 0);
    // Busy reflects same-cycle reservation.
    cyc(1, 4'd6, 4'd9, 0, 0, 0, 1, 4'd6);

    // Reset mid-operation, then reset again part way through init.
    cyc(0, 0, 0, 1, 4'd2, 16'hFFFF, 1, 4'd5);
    cyc(1, 4'd2, 4'd5, 0, 0, 0, 0, 0);
    do_reset();
    chk("rst2_data_a", 32'(rd_data_a), 32'd0);
    chk("rst2_busy_b", 32'(busy_b), 32'd0);
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_addr = 4'd2; wr_data = 16'hFFFF;
      rd_en = 1; rd_addr_a = 4'd2;
      @(posedge clk); #1;
    end
    chk("init_hold_data", 32'(rd_data_a), 32'd0);
    do_reset();
    count_init("reinit");
    cyc(1, 4'd2, 4'd5, 0, 0, 0, 0, 0);
    cyc(1, 4'd9, 4'd6, 0, 0, 0, 0, 0);

    // Address 0: normal in dut, hardwired in dut_z.
    cyc(0, 0, 0, 1, 4'd0, 16'hFFFF, 1, 4'd0);
    cyc(1, 4'd0, 4'd1, 0, 0, 0, 0, 0);
    cyc(1, 4'd1, 4'd0, 1, 4'd0, 16'h7777, 0, 0);

    // Random mix.
    for (int i = 0; i < 60; i++) begin
      cyc($urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom),
          $urandom_range(0, 1) == 1, 4'($urandom), 16'($urandom),
          $urandom_range(0, 3) == 0, 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised register file for the datapath: two registered read ports, one write port, write-to-read bypass and per-register pending (scoreboard) bits.
- Lets the control unit detect read-after-write hazards when writeback is delayed.
- After reset it runs a self-initialisation sequence, one register per cycle, instead of clearing all registers in one cycle.
- Sits between decode (read addresses, reservations) and writeback (write port).

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers.
- INIT_INDEX, 1: if 1, the init sequence writes reg[i] = i, truncated or zero-extended to DATA_W; if 0, it writes 0.
- ZERO_REG, 0: if 1, register 0 reads as 0, ignores writes and is never pending.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- rd_en  in  1  capture both read ports this cycle.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_a  out  DATA_W  registered read data, port A.
- rd_data_b  out  DATA_W  registered read data, port B.
- busy_a  out  1  registered pending flag for rd_addr_a.
- busy_b  out  1  registered pending flag for rd_addr_b.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rsv_en  in  1  mark a register pending (an instruction has issued that will write it).
- rsv_addr  in  ADDR_W  register to reserve.
- init_busy  out  1  init sequence running; all requests are ignored while high.

Behaviour:
- Reset (sampled on clk, dominates everything else):
  - rd_data_a, rd_data_b, busy_a, busy_b <= 0.
  - All pending bits <= 0.
  - Init counter <= 0; init_busy <= 1.
- Init state (INIT):
  - Each cycle: reg[cnt] <= (INIT_INDEX ? cnt : 0); cnt increments.
  - After the write to DEPTH-1, go to RUN and drop init_busy. init_busy is therefore high for exactly DEPTH cycles after the reset cycle.
  - In INIT, rd_en, wr_en and rsv_en are ignored and outputs hold 0.
  - Reset asserted during INIT restarts the sequence at cnt = 0.
- RUN state:
  - Write: on wr_en, reg[wr_addr] <= wr_data and pending[wr_addr] <= 0.
  - Read: on rd_en, rd_data_x <= reg[rd_addr_x] with 1-cycle latency. When rd_en is low, rd_data_x and busy_x hold their previous values.
  - Bypass: if wr_en and wr_addr == rd_addr_x in the same rd_en cycle, rd_data_x <= wr_data (write-first). Applies to both ports independently, including when both ports read the written address.
  - Reservation: on rsv_en, pending[rsv_addr] <= 1.
  - rsv_en and wr_en to the same address in one cycle: the reservation wins and the bit ends at 1 (a new producer has issued).
  - busy_x <= next-state pending[rd_addr_x], i.e. after this cycle's write-clear and reservation-set. This keeps busy consistent with bypassed data.
- ZERO_REG = 1:
  - Address 0 reads 0, including via bypass.
  - Writes to address 0 are dropped; reservations of address 0 are dropped; busy for address 0 is always 0.
  - Init still sweeps address 0 harmlessly.
- No other state machine states. Address arithmetic is unsigned ADDR_W; the init counter is ADDR_W+1 bits so termination is detected without wrap-around.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W and ADDR_W;
  - the state encoding (INIT, RUN);
  - a read-port request struct (en, addr).
- One natural sub-module: regfile_read_port. It does address decode, the bypass compare, ZERO_REG masking and output/busy registering. It is instantiated twice.
- Storage array, pending vector and init FSM stay in the top.

Test Plan:
- Init sweep: assert reset 1 cycle, INIT_INDEX=1 → init_busy high 16 cycles. Then reading A=5, B=15 gives rd_data_a=0x0005 and rd_data_b=0x000F one cycle after rd_en.
- Write then read: wr_en, addr 3, data 0xBEEF; next cycle read A=3 → 0xBEEF with busy_a=0. Reading B=4 → 0x0004.
- Bypass: same cycle, wr_en addr 7 data 0x1234 and rd_en A=7, B=7 → both ports 0x1234 next cycle.
- Scoreboard: rsv_en addr 9, then read A=9 → busy_a=1. Then wr_en addr 9 data 0x00AA with rd_en A=9 → rd_data_a=0x00AA, busy_a=0. Same-cycle rsv_en and wr_en to addr 9, then read → busy_a=1.
- Reset mid-operation: assert reset with pending bits set and reg[2]=0xFFFF. Also assert reset again at init cycle 8 → sequence restarts (init_busy high 16 more cycles). All busy flags end at 0; reg[2] reads 0x0002. wr_en issued during init has no effect.
- ZERO_REG=1: write 0xFFFF to addr 0 and rsv addr 0 → read A=0 gives 0x0000 and busy_a=0.
